uart_tx_serializer: RTL

UART transmitter, the transmit-side counterpart of the UART receiver datapath. Accepts one parallel byte per handshake and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. An internal prescale counter sets each bit period to PRESCALE system clocks, so the block runs on the same system clock as the receiver.

---
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state, state_n;
  logic                      tx_q, tx_n;
  logic                      busy_q, busy_n;
  logic [DATA_WIDTH-1:0]     shift_q, shift_n;
  logic [BW-1:0]             bit_q, bit_n;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_n;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_n;
  logic                      pen_q, pen_n;
  logic                      par_q, par_n;
  logic                      terminal;
  logic                      last_stop;

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

  assign terminal = (pre_q == (presc_q - PRESCALE_WIDTH'(1)));

`ifdef UART_TX_TWO_STOP_EN
  // bit_q counts completed stop bits while in STOP
  assign last_stop = (bit_q == BW'(1));
`else
  assign last_stop = 1'b1;
`endif

  always_comb begin
    state_n = state;
    tx_n    = tx_q;
    busy_n  = busy_q;
    shift_n = shift_q;
    bit_n   = bit_q;
    pre_n   = pre_q;
    presc_n = presc_q;
    pen_n   = pen_q;
    par_n   = par_q;

    if (state != IDLE) begin
      pre_n = terminal ? '0 : pre_q + PRESCALE_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (DATA_VALID) begin
          shift_n = P_DATA;
          pen_n   = PAR_EN;
          par_n   = PAR_TYP ? ~^P_DATA : ^P_DATA;
          presc_n = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
          pre_n   = '0;
          bit_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (terminal) begin
          state_n = DATA;
          tx_n    = shift_q[0];
          bit_n   = '0;
        end
      end
      DATA: begin
        if (terminal) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_n = '0;
            if (pen_q) begin
              state_n = PARITY;
              tx_n    = par_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
            bit_n   = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (terminal) begin
          state_n = STOP;
          tx_n    = 1'b1;
          bit_n   = '0;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (terminal) begin
          if (last_stop) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            bit_n   = '0;
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      pre_q   <= '0;
      presc_q <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      shift_q <= shift_n;
      bit_q   <= bit_n;
      pre_q   <= pre_n;
      presc_q <= presc_n;
      pen_q   <= pen_n;
      par_q   <= par_n;
    end
  end

endmodule
